stream_arb2: RTL

STREAM_ARB2 -- requirements
Module: stream_arb2

---
 rtl/stream_arb2_pkg.sv | 10 +
 rtl/stream_arb2_sat_counter.sv | 26 ++
 rtl/stream_arb2.sv | 82 ++++++++
 3 files changed

// File: rtl/stream_arb2_pkg.sv
// Shared constants for the two-source stream arbiter.
package stream_arb2_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;
  localparam int unsigned DATA_W        = 2;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage : stream_arb2_pkg

// File: rtl/stream_arb2_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_full;

  assign w_full  = (r_count == {W{1'b1}});
  assign o_count = r_count;

  // Increment on enable unless already saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && !w_full) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/stream_arb2.sv
// Two-source round-robin arbiter feeding a one-word output register.
module stream_arb2
  import stream_arb2_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_sel;
  logic              r_prio;

  logic              w_load;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_a_xfer;
  logic              w_b_xfer;

  // Output register may take a new word when empty or being drained.
  assign w_load = !r_out_valid || out_ready;

  // Single valid source wins outright; a tie goes to the preferred source.
  assign w_grant_a = a_valid && (!b_valid || (r_prio == SRC_A));
  assign w_grant_b = b_valid && (!a_valid || (r_prio == SRC_B));

  // rst_n gating keeps both readies low while reset is held.
  assign w_a_xfer = rst_n && w_load && w_grant_a;
  assign w_b_xfer = rst_n && w_load && w_grant_b;

  assign a_ready   = w_a_xfer;
  assign b_ready   = w_b_xfer;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sel       = r_sel;

  // Output register and priority pointer; prio always moves away from the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sel       <= SRC_A;
      r_prio      <= SRC_A;
    end else if (w_a_xfer || w_b_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_b_xfer ? b_data : a_data;
      r_sel       <= w_b_xfer ? SRC_B : SRC_A;
      r_prio      <= w_b_xfer ? SRC_A : SRC_B;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_a_xfer),
    .o_count (cnt_a)
  );

  sat_counter #(.W(CNT_W)) u_cnt_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_b_xfer),
    .o_count (cnt_b)
  );

endmodule : stream_arb2
